// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: in-order pipeline hazard scoreboard.
// Tracks destination registers of in-flight instructions from issue to
// writeback and decides, with zero latency, whether the instruction at decode
// may issue and where each of its operands should be sourced from.
// Build option: define PIPE_SCOREBOARD_FWD_EN to enable operand forwarding;
// without it every in-flight producer ahead of writeback stalls its consumer.
// The reset input i_reset is asynchronous and active-low.

module pipe_scoreboard #(
    parameter int DEPTH       = 4,
    parameter int REG_AW      = 5,
    parameter int LOAD_STAGE  = 2,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_issue_valid,
    input  logic [REG_AW-1:0] i_issue_rs,
    input  logic [REG_AW-1:0] i_issue_rt,
    input  logic              i_issue_use_rs,
    input  logic              i_issue_use_rt,
    input  logic [REG_AW-1:0] i_issue_rd,
    input  logic              i_issue_wr,
    input  logic              i_issue_load,
    input  logic              i_flush,
    output logic              o_issue_ready,
    output logic              o_stall,
    output logic [3:0]        o_fwd_sel_rs,
    output logic [3:0]        o_fwd_sel_rt,
    output logic              o_wb_valid,
    output logic [REG_AW-1:0] o_wb_rd,
    output logic [15:0]       o_stall_cnt
);

    // Slot state: index 0 is the youngest, DEPTH-1 is the writeback stage.
    logic [DEPTH-1:0]  r_v;
    logic [DEPTH-1:0]  r_wr;
    logic [DEPTH-1:0]  r_load;
    logic [REG_AW-1:0] r_rd [DEPTH];
    logic [15:0]       r_stall_cnt;

    logic       w_hit_rs, w_hit_rt;
    logic [2:0] w_k_rs, w_k_rt;
    logic       w_ld_rs, w_ld_rt;
    logic       w_near_rs, w_near_rt;
    logic       w_ldhaz_rs, w_ldhaz_rt;
    logic       w_haz_rs, w_haz_rt;
    logic [3:0] w_fwd_rs, w_fwd_rt;
    logic       w_ready, w_stall;

    // Find the youngest matching producer for each source; scanning from the
    // oldest slot down lets the youngest match overwrite any older one.
    always_comb begin
        w_hit_rs = 1'b0;
        w_k_rs   = 3'd0;
        w_ld_rs  = 1'b0;
        w_hit_rt = 1'b0;
        w_k_rt   = 3'd0;
        w_ld_rt  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_issue_use_rs && (i_issue_rs != '0) && r_v[k] && r_wr[k] &&
                (r_rd[k] == i_issue_rs)) begin
                w_hit_rs = 1'b1;
                w_k_rs   = 3'(k);
                w_ld_rs  = r_load[k];
            end
            if (i_issue_use_rt && (i_issue_rt != '0) && r_v[k] && r_wr[k] &&
                (r_rd[k] == i_issue_rt)) begin
                w_hit_rt = 1'b1;
                w_k_rt   = 3'(k);
                w_ld_rt  = r_load[k];
            end
        end
    end

    // A producer in the writeback slot writes the register file before it is
    // read, so only matches in earlier slots count as hazards.
    assign w_near_rs  = w_hit_rs && (w_k_rs != 3'(DEPTH - 1));
    assign w_near_rt  = w_hit_rt && (w_k_rt != 3'(DEPTH - 1));
    assign w_ldhaz_rs = w_near_rs && w_ld_rs && (w_k_rs < 3'(LOAD_STAGE));
    assign w_ldhaz_rt = w_near_rt && w_ld_rt && (w_k_rt < 3'(LOAD_STAGE));

`ifdef PIPE_SCOREBOARD_FWD_EN
    // Forwarding: only a load whose data is not yet available stalls.
    assign w_haz_rs = w_ldhaz_rs;
    assign w_haz_rt = w_ldhaz_rt;
    assign w_fwd_rs = (w_near_rs && !w_ldhaz_rs) ? (4'(w_k_rs) + 4'd1) : 4'd0;
    assign w_fwd_rt = (w_near_rt && !w_ldhaz_rt) ? (4'(w_k_rt) + 4'd1) : 4'd0;
`else
    // No forwarding: any pending producer stalls. The load term is already
    // implied by the near term and keeps the load tracking in this build.
    assign w_haz_rs = w_near_rs | w_ldhaz_rs;
    assign w_haz_rt = w_near_rt | w_ldhaz_rt;
    assign w_fwd_rs = 4'd0;
    assign w_fwd_rt = 4'd0;
`endif

    // Issue handshake; held off while reset is asserted so all outputs read 0.
    assign w_ready = i_reset && i_issue_valid && !i_flush && !w_haz_rs && !w_haz_rt;
    assign w_stall = i_reset && i_issue_valid && !w_ready;

    // Advance the slot pipeline each cycle; a flush kills the youngest
    // FLUSH_DEPTH in-flight entries as they move and blocks the new issue.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_v    <= '0;
            r_wr   <= '0;
            r_load <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_rd[k] <= '0;
            end
        end else begin
            r_v[0]    <= w_ready;
            r_wr[0]   <= w_ready && i_issue_wr;
            r_load[0] <= w_ready && i_issue_load;
            r_rd[0]   <= i_issue_rd;
            for (int k = 1; k < DEPTH; k++) begin
                r_v[k]    <= r_v[k-1] && !(i_flush && ((k - 1) < FLUSH_DEPTH));
                r_wr[k]   <= r_wr[k-1];
                r_load[k] <= r_load[k-1];
                r_rd[k]   <= r_rd[k-1];
            end
        end
    end

    // Saturating count of stall cycles.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_issue_ready = w_ready;
    assign o_stall       = w_stall;
    assign o_fwd_sel_rs  = w_fwd_rs;
    assign o_fwd_sel_rt  = w_fwd_rt;
    assign o_wb_valid    = r_v[DEPTH-1] && r_wr[DEPTH-1];
    assign o_wb_rd       = r_rd[DEPTH-1];
    assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb_pipe_scoreboard: directed self-checking bench for pipe_scoreboard with
// default parameters (DEPTH=4, LOAD_STAGE=2, FLUSH_DEPTH=1). Expectations
// adapt to whether PIPE_SCOREBOARD_FWD_EN is defined.

module tb_pipe_scoreboard;

`ifdef PIPE_SCOREBOARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Hand-derived expectations for the two builds.
    localparam int       ADD_STALLS = FWD ? 0 : 3;
    localparam bit [3:0] ADD_FWD    = FWD ? 4'd1 : 4'd0;
    localparam int       LD_STALLS  = FWD ? 2 : 3;
    localparam bit [3:0] LD_FWD     = FWD ? 4'd3 : 4'd0;

    logic        clk;
    logic        resetN;
    logic        issueValid;
    logic [4:0]  issueRs;
    logic [4:0]  issueRt;
    logic        issueUseRs;
    logic        issueUseRt;
    logic [4:0]  issueRd;
    logic        issueWr;
    logic        issueLoad;
    logic        flush;
    logic        issueReady;
    logic        stall;
    logic [3:0]  fwdSelRs;
    logic [3:0]  fwdSelRt;
    logic        wbValid;
    logic [4:0]  wbRd;
    logic [15:0] stallCnt;

    int vectors;
    int miscompares;

    pipe_scoreboard dut (
        .i_clk          (clk),
        .i_reset        (resetN),
        .i_issue_valid  (issueValid),
        .i_issue_rs     (issueRs),
        .i_issue_rt     (issueRt),
        .i_issue_use_rs (issueUseRs),
        .i_issue_use_rt (issueUseRt),
        .i_issue_rd     (issueRd),
        .i_issue_wr     (issueWr),
        .i_issue_load   (issueLoad),
        .i_flush        (flush),
        .o_issue_ready  (issueReady),
        .o_stall        (stall),
        .o_fwd_sel_rs   (fwdSelRs),
        .o_fwd_sel_rt   (fwdSelRt),
        .o_wb_valid     (wbValid),
        .o_wb_rd        (wbRd),
        .o_stall_cnt    (stallCnt)
    );

    // Free-running clock: rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one decode slot worth of inputs.
    task automatic applyStimulus(input logic valid, input logic useRs, input logic [4:0] rs,
                                 input logic useRt, input logic [4:0] rt,
                                 input logic wr, input logic [4:0] rd, input logic load);
        issueValid = valid;
        issueUseRs = useRs;
        issueRs    = rs;
        issueUseRt = useRt;
        issueRt    = rt;
        issueWr    = wr;
        issueRd    = rd;
        issueLoad  = load;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        flush = 1'b0;
    endtask

    // Advance to the next falling edge, i.e. one rising edge later.
    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        idle();
        resetN = 1'b0;
        #2;
        resetN = 1'b1;
        nextCycle();
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        doReset();
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 1'b0);
        #1;
        vectors++;
        if (issueReady !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_first_issue: ready=%0b expected 1", issueReady);
        end
        nextCycle();
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0);
        nextCycle();
        idle();
        nextCycle();
        // Slots 1..3 hold rd 3,2,1; present a reader of r3 sitting in slot 1.
        applyStimulus(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        vectors++;
        if ({wbValid, wbRd, issueReady, stall, fwdSelRs} !== {1'b1, 5'd1, FWD, ~FWD, FWD ? 4'd2 : 4'd0}) begin
            miscompares++;
            $display("[TB] FAIL reset_prestate: wb=%0b rd=%0d ready=%0b stall=%0b fwd=%0d expected wb=1 rd=1 ready=%0b stall=%0b fwd=%0d",
                     wbValid, wbRd, issueReady, stall, fwdSelRs, FWD, ~FWD, FWD ? 2 : 0);
        end
        #1;
        resetN = 1'b0;
        #1;
        vectors++;
        if ({issueReady, stall, wbValid, wbRd, fwdSelRs, fwdSelRt, stallCnt} !== 31'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_async_clear: ready=%0b stall=%0b wb=%0b rd=%0d fwdRs=%0d fwdRt=%0d cnt=%0d expected all 0",
                     issueReady, stall, wbValid, wbRd, fwdSelRs, fwdSelRt, stallCnt);
        end
        nextCycle();
        #1;
        vectors++;
        if ({issueReady, stall, wbValid, stallCnt} !== 19'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_held: ready=%0b stall=%0b wb=%0b cnt=%0d expected all 0",
                     issueReady, stall, wbValid, stallCnt);
        end
        resetN = 1'b1;
        #1;
        vectors++;
        if ({issueReady, stall, fwdSelRs} !== {1'b1, 1'b0, 4'd0}) begin
            miscompares++;
            $display("[TB] FAIL reset_resume: ready=%0b stall=%0b fwd=%0d expected ready=1 stall=0 fwd=0",
                     issueReady, stall, fwdSelRs);
        end
        nextCycle();
        idle();
        #1;
        vectors++;
        if ({wbValid, stallCnt} !== 17'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_no_survivor: wb=%0b cnt=%0d expected 0 0", wbValid, stallCnt);
        end
    endtask

    task automatic test_forward();
        $display("[TB] test_forward");
        doReset();
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd6, 1'b0);
        for (int i = 0; i < ADD_STALLS; i++) begin
            #1;
            vectors++;
            if ({issueReady, stall} !== 2'b01) begin
                miscompares++;
                $display("[TB] FAIL fwd_stall_%0d: ready=%0b stall=%0b expected ready=0 stall=1", i, issueReady, stall);
            end
            nextCycle();
        end
        #1;
        vectors++;
        if ({issueReady, stall, fwdSelRs, stallCnt} !== {1'b1, 1'b0, ADD_FWD, 16'(ADD_STALLS)}) begin
            miscompares++;
            $display("[TB] FAIL fwd_accept: ready=%0b stall=%0b fwd=%0d cnt=%0d expected ready=1 stall=0 fwd=%0d cnt=%0d",
                     issueReady, stall, fwdSelRs, stallCnt, ADD_FWD, ADD_STALLS);
        end
        nextCycle();
        idle();
    endtask

    task automatic test_load_use();
        $display("[TB] test_load_use");
        doReset();
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < LD_STALLS; i++) begin
            #1;
            vectors++;
            if ({issueReady, stall} !== 2'b01) begin
                miscompares++;
                $display("[TB] FAIL load_stall_%0d: ready=%0b stall=%0b expected ready=0 stall=1", i, issueReady, stall);
            end
            nextCycle();
        end
        #1;
        vectors++;
        if ({issueReady, stall, fwdSelRt, stallCnt} !== {1'b1, 1'b0, LD_FWD, 16'(LD_STALLS)}) begin
            miscompares++;
            $display("[TB] FAIL load_accept: ready=%0b stall=%0b fwdRt=%0d cnt=%0d expected ready=1 stall=0 fwdRt=%0d cnt=%0d",
                     issueReady, stall, fwdSelRt, stallCnt, LD_FWD, LD_STALLS);
        end
        nextCycle();
        idle();
    endtask

    task automatic test_zero_and_youngest();
        $display("[TB] test_zero_and_youngest");
        doReset();
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        vectors++;
        if ({issueReady, stall, fwdSelRs} !== {1'b1, 1'b0, 4'd0}) begin
            miscompares++;
            $display("[TB] FAIL reg_zero: ready=%0b stall=%0b fwd=%0d expected ready=1 stall=0 fwd=0",
                     issueReady, stall, fwdSelRs);
        end
        nextCycle();
        // Build slots: 2 -> r9, 1 -> r10, 0 -> r9.
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd10, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
        nextCycle();
        // Addresses present but use bits clear: nothing may match.
        applyStimulus(1'b1, 1'b0, 5'd9, 1'b0, 5'd10, 1'b0, 5'd0, 1'b0);
        #1;
        vectors++;
        if ({issueReady, stall, fwdSelRs, fwdSelRt} !== {1'b1, 1'b0, 4'd0, 4'd0}) begin
            miscompares++;
            $display("[TB] FAIL use_bits_clear: ready=%0b stall=%0b fwdRs=%0d fwdRt=%0d expected ready=1 stall=0 fwd 0 0",
                     issueReady, stall, fwdSelRs, fwdSelRt);
        end
        applyStimulus(1'b1, 1'b1, 5'd9, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0);
        #1;
        vectors++;
        if ({issueReady, stall, fwdSelRs, fwdSelRt} !== {FWD, ~FWD, FWD ? 4'd1 : 4'd0, FWD ? 4'd2 : 4'd0}) begin
            miscompares++;
            $display("[TB] FAIL youngest_match: ready=%0b stall=%0b fwdRs=%0d fwdRt=%0d expected ready=%0b stall=%0b fwdRs=%0d fwdRt=%0d",
                     issueReady, stall, fwdSelRs, fwdSelRt, FWD, ~FWD, FWD ? 1 : 0, FWD ? 2 : 0);
        end
        nextCycle();
        idle();
    endtask

    task automatic test_flush();
        logic expWb [4];
        expWb = '{1'b0, 1'b1, 1'b0, 1'b0};
        $display("[TB] test_flush");
        doReset();
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd11, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd12, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd13, 1'b0);
        flush = 1'b1;
        #1;
        vectors++;
        if ({issueReady, stall, wbValid} !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL flush_block: ready=%0b stall=%0b wb=%0b expected ready=0 stall=1 wb=0",
                     issueReady, stall, wbValid);
        end
        nextCycle();
        idle();
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (wbValid !== expWb[i] || (expWb[i] && wbRd !== 5'd11)) begin
                miscompares++;
                $display("[TB] FAIL flush_wb_%0d: wb=%0b rd=%0d expected wb=%0b rd=11", i, wbValid, wbRd, expWb[i]);
            end
            nextCycle();
        end
        // Pipeline now empty: a reader of r12 or r11 issues immediately.
        applyStimulus(1'b1, 1'b1, 5'd12, 1'b1, 5'd11, 1'b0, 5'd0, 1'b0);
        #1;
        vectors++;
        if ({issueReady, stall, wbValid, stallCnt} !== {1'b1, 1'b0, 1'b0, 16'd1}) begin
            miscompares++;
            $display("[TB] FAIL flush_empty: ready=%0b stall=%0b wb=%0b cnt=%0d expected ready=1 stall=0 wb=0 cnt=1",
                     issueReady, stall, wbValid, stallCnt);
        end
        nextCycle();
        idle();
    endtask

    task automatic test_saturation();
        $display("[TB] test_saturation");
        doReset();
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        flush = 1'b1;
        repeat (65534) nextCycle();
        #1;
        vectors++;
        if ({stall, stallCnt} !== {1'b1, 16'hFFFE}) begin
            miscompares++;
            $display("[TB] FAIL sat_before: stall=%0b cnt=%0h expected stall=1 cnt=fffe", stall, stallCnt);
        end
        nextCycle();
        #1;
        vectors++;
        if (stallCnt !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL sat_reach: cnt=%0h expected ffff", stallCnt);
        end
        repeat (4465) nextCycle();
        #1;
        vectors++;
        if (stallCnt !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL sat_hold: cnt=%0h expected ffff", stallCnt);
        end
        idle();
    endtask

    // Run every scenario in order, then report.
    initial begin
        vectors     = 0;
        miscompares = 0;
        resetN      = 1'b0;
        idle();
        test_reset();
        test_forward();
        test_load_use();
        test_zero_and_youngest();
        test_flush();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_scoreboard.md
PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of tracked stages from issue to writeback (slot 0 youngest, slot DEPTH-1 writeback); legal range 2..8.
REQ-002 SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 SHALL have parameter LOAD_STAGE, default 2, first slot index at which load data is forwardable; legal range 1..DEPTH-1.
REQ-004 SHALL have parameter FLUSH_DEPTH, default 1, number of youngest slots killed by flush; legal range 0..DEPTH-1.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 issue_valid  input  1  decode presents an instruction.
REQ-008 issue_rs, issue_rt  input  REG_AW  source register addresses.
REQ-009 issue_use_rs, issue_use_rt  input  1  source actually read.
REQ-010 issue_rd  input  REG_AW  destination; issue_wr  input  1  writes rd; issue_load  input  1  is a load.
REQ-011 flush  input  1  kill younger in-flight work (branch taken).
REQ-012 issue_ready  output  1  instruction accepted this cycle; stall  output  1  = issue_valid & ~issue_ready.
REQ-013 fwd_sel_rs, fwd_sel_rt  output  4  operand source: 0 = register file, k+1 = slot k.
REQ-014 wb_valid  output  1, wb_rd  output  REG_AW  writeback request from slot DEPTH-1.
REQ-015 stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-016 Each slot SHALL hold {v, wr, rd, load}; every rising edge slot k SHALL move to k+1; slot DEPTH-1 retires.
REQ-017 Slot 0 SHALL load {1, issue_wr, issue_rd, issue_load} when issue_ready, else a bubble (v=0).
REQ-018 A source SHALL match slot k iff use bit set, address non-zero, and slot k has v & wr & rd equal to the address.
REQ-019 Register 0 SHALL never match, stall or forward.
REQ-020 Match in slot DEPTH-1 SHALL NOT stall (write-before-read in register file); fwd_sel SHALL be 0 for it.
REQ-021 With multiple matches the youngest (lowest k) SHALL determine stall/forward.
REQ-022 issue_ready, stall, fwd_sel SHALL be combinational from current inputs and slot state, zero cycles latency.
REQ-023 flush SHALL, at the edge, invalidate what would become slots 0..FLUSH_DEPTH-1, and issue_ready SHALL be 0 while flush is high.
REQ-024 stall_cnt SHALL increment on each cycle with stall=1 and hold at 16'hFFFF.
REQ-025 wb_valid SHALL equal slot DEPTH-1 v & wr; wb_rd SHALL equal its rd.
REQ-026 issue_valid=0 SHALL give issue_ready=0, stall=0, bubble inserted.

Reset
REQ-027 reset low SHALL immediately clear all slots, stall_cnt=0, wb_valid=0, wb_rd=0, issue_ready=0, fwd_sel=0, independent of clk.
REQ-028 Deassertion mid-stream SHALL resume from empty state; no in-flight entry survives.

Configuration
REQ-029 Macro PIPE_SCOREBOARD_FWD_EN SHALL select forwarding.
REQ-030 Defined: a youngest match stalls only if that slot has load=1 and k < LOAD_STAGE; otherwise fwd_sel = k+1 (0 for slot DEPTH-1).
REQ-031 Undefined: any youngest match in slots 0..DEPTH-2 stalls; fwd_sel outputs are constant 0.

Verification
REQ-032 Reset low mid-stream with 3 valid slots -> all outputs 0 asynchronously; after release first issue accepted with no stall.
REQ-033 FWD_EN, DEPTH=4: issue add rd=5, next cycle issue rs=5 -> issue_ready=1, fwd_sel_rs=1; without FWD_EN -> stall for 3 cycles, then accepted with fwd_sel_rs=0, stall_cnt=3.
REQ-034 FWD_EN: load rd=7 then rt=7 next cycle -> 2 stall cycles (LOAD_STAGE=2), then fwd_sel_rt=3.
REQ-035 rd=0 writer followed by rs=0 reader -> no stall, fwd_sel_rs=0; rd=9 in slots 0 and 2 -> fwd_sel selects slot 0 (value 1).
REQ-036 flush with issue_valid=1 and 2 valid slots, FLUSH_DEPTH=1 -> issue_ready=0, only older entry reaches wb_valid, DEPTH cycles later pipeline empty.
REQ-037 Hold hazard 70000 cycles -> stall_cnt saturates at 65535, no wrap.
